// File: rtl/frame_sign_feeder.sv
// -----------------------------------------------------------------------------
// frame_sign_feeder
//
// Upstream neighbour of the sign-inversion stage. It collects one frame of
// DEPTH signed samples over a valid/ready handshake into a local register
// buffer. It then replays the frame one word per clock inside a contiguous
// enable window, with the word's sign bit presented alongside it. The
// downstream finish strobe is checked against the local word count, and a
// one-cycle pulse marks each completed frame.
//
// Ports:
//   iClk        clock, rising edge
//   iRst_n      asynchronous active-low reset
//   iAbort      synchronous abort, discards the current frame (highest priority)
//   iValid      upstream sample valid
//   iData       upstream sample [DW-1:0]
//   oReady      sample accepted this cycle when iValid is high (state == FILL)
//   oEnable     enable window to the downstream stage (registered)
//   oSign       sign bit of the presented word (registered)
//   oData       presented word, zero outside the window (registered)
//   iFinish     downstream finish strobe, expected on the last word only
//   oFrameDone  one-cycle pulse after the last word of a frame
//   oSeqErr     sticky: iFinish disagreed with the word count
//   oBusy       high while draining and during the done cycle
// -----------------------------------------------------------------------------
module frame_sign_feeder #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,   // power of two, equal to 2**AW
  parameter int AW    = 5
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iAbort,
  input  logic          iValid,
  input  logic [DW-1:0] iData,
  output logic          oReady,
  output logic          oEnable,
  output logic          oSign,
  output logic [DW-1:0] oData,
  input  logic          iFinish,
  output logic          oFrameDone,
  output logic          oSeqErr,
  output logic          oBusy
);

  typedef enum logic [1:0] {
    S_FILL,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;     // index of the word currently on oData while draining
  logic [DW-1:0] r_mem [DEPTH];

  logic          r_enable;
  logic          r_sign;
  logic [DW-1:0] r_data;
  logic          r_frame_done;
  logic          r_seq_err;
  logic          r_busy;

  logic          w_accept;
  logic          w_last_rd;
  logic [AW-1:0] w_rd_sel;
  logic [DW-1:0] w_rd_word;

  assign oReady    = (r_state == S_FILL);
  assign w_accept  = iValid && oReady && !iAbort;
  assign w_last_rd = (r_state == S_DRAIN) && (r_rd_ptr == LAST_IDX);

  // The output register is loaded with the word that will be on display in
  // the next cycle: word 0 when entering DRAIN, otherwise the following word.
  assign w_rd_sel  = (r_state == S_DRAIN) ? r_rd_ptr + AW'(1) : '0;
  assign w_rd_word = r_mem[w_rd_sel];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    if (iAbort) begin
      w_next = S_FILL;
    end else begin
      unique case (r_state)
        S_FILL:  if (w_accept && (r_wr_ptr == LAST_IDX)) w_next = S_DRAIN;
        S_DRAIN: if (w_last_rd) w_next = S_DONE;
        S_DONE:  w_next = S_FILL;
        default: w_next = S_FILL;
      endcase
    end
  end

  // NOTE: state and all sequential registers use non-blocking assignments so
  // every always_ff sees the pre-edge values of the others.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= S_FILL;
    else         r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // Frame buffer
  // ---------------------------------------------------------------------------
  // NOTE: the buffer has no reset; its contents are only read after a full
  // frame has been written, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge iClk) begin
    if (w_accept) r_mem[r_wr_ptr] <= iData;
  end

  // Pointers wrap naturally because DEPTH == 2**AW.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (iAbort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept)             r_wr_ptr <= r_wr_ptr + AW'(1);
      if (r_state == S_DRAIN)   r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, computed from the state being entered
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_enable     <= 1'b0;
      r_sign       <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
      r_seq_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else if (iAbort) begin
      r_enable     <= 1'b0;
      r_sign       <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
      r_seq_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= (w_next == S_DONE);
      r_busy       <= (w_next != S_FILL);
      if (w_next == S_DRAIN) begin
        r_enable <= 1'b1;
        r_data   <= w_rd_word;
        r_sign   <= w_rd_word[DW-1];
      end else begin
        // Zeroed, disabled input resets the downstream step counter.
        r_enable <= 1'b0;
        r_data   <= '0;
        r_sign   <= 1'b0;
      end
      // Finish must coincide with the last presented word and nowhere else.
      if ((r_state == S_DRAIN) && (iFinish != w_last_rd)) r_seq_err <= 1'b1;
    end
  end

  assign oEnable    = r_enable;
  assign oSign      = r_sign;
  assign oData      = r_data;
  assign oFrameDone = r_frame_done;
  assign oSeqErr    = r_seq_err;
  assign oBusy      = r_busy;

endmodule

// File: tb/tb_frame_sign_feeder.sv
// -----------------------------------------------------------------------------
// tb_frame_sign_feeder
//
// Stimulus processes drive frames, aborts, resets and the downstream finish
// strobe. A frame-level reference model turns every accepted sample into an
// entry of a replay queue; a monitor on the falling edge pops that queue
// whenever a word is expected and compares all outputs each cycle.
// -----------------------------------------------------------------------------
module tb_frame_sign_feeder;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          iClk   = 1'b0;
  logic          iRst_n = 1'b0;
  logic          iAbort = 1'b0;
  logic          iValid = 1'b0;
  logic [DW-1:0] iData  = '0;
  logic          iFinish = 1'b0;
  logic          oReady;
  logic          oEnable;
  logic          oSign;
  logic [DW-1:0] oData;
  logic          oFrameDone;
  logic          oSeqErr;
  logic          oBusy;

  frame_sign_feeder #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iAbort     (iAbort),
    .iValid     (iValid),
    .iData      (iData),
    .oReady     (oReady),
    .oEnable    (oEnable),
    .oSign      (oSign),
    .oData      (oData),
    .iFinish    (iFinish),
    .oFrameDone (oFrameDone),
    .oSeqErr    (oSeqErr),
    .oBusy      (oBusy)
  );

  always #5 iClk = ~iClk;

  int n_tests = 0;
  int n_fail  = 0;
  int fin_target = DEPTH - 1;   // enabled-cycle index at which iFinish is raised

  // Reference model state (frame level)
  logic [DW-1:0] pend[$];       // accepted samples of the frame being filled
  logic [DW-1:0] frame_q[$];    // words still to be replayed, in order
  int            drain_cnt = 0;
  bit            exp_en = 1'b0;
  bit            exp_done = 1'b0;
  bit            exp_seqerr = 1'b0;
  logic [DW-1:0] exp_w;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Present one sample and hold it until it is accepted.
  task automatic send_word(input logic [DW-1:0] w);
    int guard;
    guard  = 0;
    iValid = 1'b1;
    iData  = w;
    while (!oReady && guard < 500) begin
      tick();
      guard++;
    end
    check("ready_wait", oReady, 1);
    tick();
    iValid = 1'b0;
    iData  = $urandom;
  endtask

  // kind: 0 = 1..DEPTH, 1 = alternating sign extremes, 2 = 0xA0+i, 3 = random
  task automatic send_frame(input int kind, input int gap_min, input int gap_max);
    logic [DW-1:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      case (kind)
        0:       w = DW'(i + 1);
        1:       w = (i % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        2:       w = DW'(32'hA0 + i);
        default: w = $urandom;
      endcase
      send_word(w);
      if (gap_max > 0) repeat ($urandom_range(gap_min, gap_max)) tick();
    end
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!oFrameDone && guard < 300) begin
      tick();
      guard++;
    end
    check("frame_done_wait", oFrameDone, 1);
    tick();
  endtask

  task automatic wait_enable();
    int guard;
    guard = 0;
    while (!oEnable && guard < 300) begin
      tick();
      guard++;
    end
    check("enable_wait", oEnable, 1);
  endtask

  task automatic pulse_abort();
    iAbort = 1'b1;
    iValid = 1'b1;             // a coincident write must be discarded
    iData  = $urandom;
    tick();
    iAbort = 1'b0;
    iValid = 1'b0;
  endtask

  // Downstream stand-in: raises iFinish at enabled-cycle index fin_target,
  // and drives noise on iFinish outside the window (it must be ignored).
  initial begin
    int fin_cnt;
    fin_cnt = 0;
    forever begin
      @(posedge iClk);
      #1;
      if (!iRst_n || !oEnable) begin
        fin_cnt = 0;
        iFinish = 1'($urandom_range(0, 1));
      end else begin
        iFinish = (fin_cnt == fin_target);
        fin_cnt++;
      end
    end
  end

  // Monitor + reference model
  initial begin
    forever begin
      @(negedge iClk);
      if (!iRst_n) begin
        pend.delete();
        frame_q.delete();
        exp_en     = 1'b0;
        exp_done   = 1'b0;
        exp_seqerr = 1'b0;
        drain_cnt  = 0;
      end

      check("enable", oEnable, exp_en);
      if (exp_en) begin
        exp_w = frame_q.pop_front();
        check("data", oData, exp_w);
        check("sign", oSign, exp_w[DW-1]);
      end else begin
        check("data_idle", oData, 0);
        check("sign_idle", oSign, 0);
      end
      check("frame_done", oFrameDone, exp_done);
      check("busy", oBusy, exp_en || exp_done);
      check("ready", oReady, !(exp_en || exp_done));
      check("seq_err", oSeqErr, exp_seqerr);

      if (iRst_n) begin
        if (iAbort) begin
          pend.delete();
          frame_q.delete();
          exp_en     = 1'b0;
          exp_done   = 1'b0;
          exp_seqerr = 1'b0;
        end else if (exp_en) begin
          if (iFinish != (drain_cnt == DEPTH - 1)) exp_seqerr = 1'b1;
          drain_cnt++;
          if (drain_cnt == DEPTH) begin
            exp_en   = 1'b0;
            exp_done = 1'b1;
          end
        end else if (exp_done) begin
          exp_done = 1'b0;
        end else if (iValid) begin
          pend.push_back(iData);
          if (pend.size() == DEPTH) begin
            frame_q = pend;
            pend.delete();
            exp_en    = 1'b1;
            drain_cnt = 0;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    repeat (3) @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    tick();

    // Incrementing frame, then alternating-sign frame presented while the
    // first one drains (iValid held high with oReady low).
    fin_target = DEPTH - 1;
    send_frame(0, 0, 0);
    send_frame(1, 0, 0);
    wait_done();

    // Gapped upstream: a sample every third cycle.
    send_frame(3, 2, 2);
    wait_done();

    // Finish one word early: sticky error held through the next frame.
    fin_target = DEPTH - 2;
    send_frame(3, 0, 0);
    wait_done();
    fin_target = DEPTH - 1;
    send_frame(3, 0, 1);
    wait_done();
    check("seq_err_held", oSeqErr, 1);
    pulse_abort();
    tick();
    check("seq_err_cleared", oSeqErr, 0);

    // Abort after ten accepted words; only the new frame may be replayed.
    for (int i = 0; i < 10; i++) send_word($urandom);
    pulse_abort();
    send_frame(2, 0, 0);
    wait_done();

    // Abort in the middle of a replay.
    send_frame(3, 0, 1);
    wait_enable();
    repeat (5) tick();
    pulse_abort();
    repeat (2) tick();

    // Reset while index 15 is presented.
    send_frame(3, 0, 2);
    wait_enable();
    repeat (15) tick();
    iRst_n = 1'b0;
    #1;
    check("rst_enable_async", oEnable, 0);
    check("rst_data_async", oData, 0);
    tick();
    tick();
    iRst_n = 1'b1;
    check("ready_after_reset", oReady, 1);
    send_frame(3, 0, 0);
    wait_done();

    // Random back-to-back frames with random gaps.
    repeat (3) send_frame(3, 0, 3);
    wait_done();

    repeat (4) tick();
    check("replay_queue_empty", frame_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_sign_feeder.md
Name: frame_sign_feeder

Overview:
- Upstream neighbour of the sign-inversion stage in the 1024-point processing chain.
- Collects a frame of DEPTH signed samples from the acquisition stream via valid/ready into a local register buffer.
- Replays the frame one word per clock with a contiguous enable window, a per-word sign flag and the raw word.
- Checks the downstream stage's finish strobe against its own word count and reports frame completion.

Parameters:
- DW, 32, sample width in bits; the sign is bit DW-1.
- DEPTH, 32, words per frame; must be a power of 2 and match the downstream step window.
- AW, 5, pointer width, log2(DEPTH).

Ports:
- iClk  in  1  clock, rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iAbort  in  1  synchronous abort; discards the current frame.
- iValid  in  1  upstream sample valid.
- iData  in  DW  upstream sample.
- oReady  out  1  feeder accepts a sample this cycle.
- oEnable  out  DW-independent 1  enable window to the downstream stage.
- oSign  out  1  sign of the presented word (bit DW-1).
- oData  out  DW  presented word.
- iFinish  in  1  downstream finish strobe.
- oFrameDone  out  1  one-cycle pulse when a frame has been replayed.
- oSeqErr  out  1  sticky: iFinish was out of step with the word count.
- oBusy  out  1  high in DRAIN and DONE.

Behaviour:
- Reset (async, iRst_n=0):
  - state=FILL; wr_ptr=rd_ptr=0.
  - oEnable=0, oSign=0, oData=0, oFrameDone=0, oSeqErr=0, oBusy=0.
  - Buffer contents are don't-care.
- All outputs are registered except oReady, which equals (state==FILL).
- FILL:
  - On iValid&&oReady, write mem[wr_ptr]<=iData and increment wr_ptr.
  - When the write at wr_ptr==DEPTH-1 is accepted, wr_ptr wraps to 0 and the next state is DRAIN.
  - iValid with oReady=0 is ignored; no write takes place and upstream must hold the sample.
- DRAIN, DEPTH cycles:
  - Each cycle: oEnable=1, oData=mem[rd_ptr], oSign=mem[rd_ptr][DW-1], rd_ptr++.
  - The first DRAIN cycle presents word 0, in the cycle after the last FILL write (latency 1 clock).
  - Words are presented strictly in arrival order, with no gaps.
  - At the cycle presenting rd_ptr==DEPTH-1, the next state is DONE and rd_ptr wraps to 0.
- Finish check, DRAIN cycles only:
  - iFinish is expected high exactly in the cycle where the presented index is DEPTH-1, i.e. the 32nd enabled cycle.
  - iFinish=1 at any other index, or iFinish=0 at index DEPTH-1, sets oSeqErr=1.
  - oSeqErr is cleared only by reset or iAbort.
  - iFinish is ignored outside DRAIN.
- DONE, exactly 1 cycle:
  - oEnable=0, oData=0, oSign=0; this resets the downstream step counter.
  - oFrameDone=1 for this cycle only.
  - Next state is FILL.
- Outside DRAIN, oEnable=0, oData=0 and oSign=0, so the downstream stage sees a zeroed, disabled input.
- iAbort=1 in any state:
  - Next cycle: state=FILL, pointers=0, oEnable=0, oData=0, oSign=0, oSeqErr=0, oFrameDone=0.
  - A write coincident with iAbort is discarded.
  - iAbort has priority over every other event.
- Reset asserted mid-DRAIN drops oEnable immediately (async) and the partial frame is lost.
- Back-to-back frames: the minimum frame period is DEPTH (fill) + DEPTH (drain) + 1 (done) cycles = 65 for DEPTH=32.
- Width rules: the buffer is DEPTH x DW; pointers wrap modulo DEPTH; there is no arithmetic on data.

Test Plan:
- Reset, then stream 32 words 0x00000001..0x00000020 with iValid=1 continuously and iFinish tied to "index==31" → oReady drops after the 32nd accept. Next cycle oEnable=1 with oData=0x1, then 0x2..0x20 on consecutive cycles, oSign=0. DONE cycle has oFrameDone=1, oEnable=0; oSeqErr stays 0.
- Frame with words alternating 0x80000000 and 0x7FFFFFFF → oSign toggles 1,0,1,… in DRAIN; oData passes each word unchanged.
- Gapped upstream (iValid on every 3rd cycle) → DRAIN still starts 1 cycle after the 32nd accept and presents 32 contiguous words.
- iFinish pulsed at index 30 instead of 31 → oSeqErr=1 from the next cycle and held through following frames. A subsequent iAbort clears it to 0.
- iAbort after 10 words are accepted, then 32 new words 0xA0..0xBF → replay starts with 0xA0; none of the aborted words appear.
- iRst_n=0 at DRAIN index 15 → oEnable=0 and oData=0 immediately. After release, oReady=1 and wr_ptr=0.
